// File: rtl/fbrc_pkg.sv
// Shared constants for the fbrc ripple counter.
package fbrc_pkg;
  localparam int FBRC_DEFAULT_WIDTH = 4;
endpackage

// File: rtl/fbrc_stage.sv
// One ripple stage: toggles on request and flags a 1->0 transition seen on the last edge.
module fbrc_stage
  import fbrc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic toggle,
  output logic q,
  output logic fell
);

  logic p;

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= 1'b0;
      p <= 1'b0;
    end else begin
      p <= q;
      if (toggle) q <= ~q;
    end
  end

  // p holds the previous q, so this is high for exactly one cycle after a fall
  assign fell = p & ~q;

endmodule

// File: rtl/fbrc_async.sv
// Ripple up counter modelled in one clock domain; each carry costs one clock per stage.
module fbrc_async
  import fbrc_pkg::*;
#(
  parameter int WIDTH = FBRC_DEFAULT_WIDTH
) (
  output logic [WIDTH-1:0] out,
  input  logic             clk,
  input  logic             reset
);

  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] tog;

  assign tog[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    if (i < WIDTH - 1) begin : g_mid
      fbrc_stage u_stage (
        .clk    (clk),
        .reset  (reset),
        .toggle (tog[i]),
        .q      (q[i]),
        .fell   (tog[i+1])
      );
    end else begin : g_top
      // The top stage's fall has no consumer, so the count wraps silently.
      logic unused_fell;
      fbrc_stage u_stage (
        .clk    (clk),
        .reset  (reset),
        .toggle (tog[i]),
        .q      (q[i]),
        .fell   (unused_fell)
      );
    end
  end

  assign out = q;

endmodule

// File: tb/tb_fbrc_async.sv
// Bench for fbrc_async at widths 4, 1 and 8 against a closed-form ripple-timing model.
module tb_fbrc_async;

  logic       clk;
  logic       reset;
  logic [3:0] out4;
  logic [0:0] out1;
  logic [7:0] out8;

  int n_checks;
  int n_errors;
  int n_edges;  // edges since reset release (0 while in reset)

  fbrc_async #(.WIDTH(4)) dut4 (.out(out4), .clk(clk), .reset(reset));
  fbrc_async #(.WIDTH(1)) dut1 (.out(out1), .clk(clk), .reset(reset));
  fbrc_async #(.WIDTH(8)) dut8 (.out(out8), .clk(clk), .reset(reset));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stage i's k-th toggle lands at edge i + k*2^i after release, so its
  // value is the parity of floor((n - i) / 2^i).
  function automatic logic [7:0] model(input int w, input int n);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < w; i++)
      if (n >= i) v[i] = ((n - i) >> i) & 1;
    return v;
  endfunction

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n_edges);
    end
  endtask

  task automatic step(input logic rst);
    reset = rst;
    @(posedge clk);
    #1;
    n_edges = rst ? 0 : n_edges + 1;
    check("w4", {4'b0, out4}, model(4, n_edges));
    check("w1", {7'b0, out1}, model(1, n_edges));
    check("w8", out8, model(8, n_edges));
  endtask

  int seq4 [11] = '{1, 0, 3, 2, 1, 4, 7, 6, 5, 0, 11};
  int seq1 [3]  = '{1, 0, 1};

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_edges  = 0;
    reset    = 1'b1;
    #2;

    // reset from power-up, held for several edges
    for (int k = 0; k < 3; k++) begin
      step(1'b1);
      check("rst_w4", {4'b0, out4}, 8'd0);
    end

    // release sequence against literal tables
    for (int k = 0; k < 11; k++) begin
      step(1'b0);
      check("seq_w4", {4'b0, out4}, seq4[k][7:0]);
      if (k < 3) check("seq_w1", {7'b0, out1}, seq1[k][7:0]);
    end

    // periodicity and wrap of the 4-bit counter over many edges
    for (int k = 0; k < 200; k++) step(1'b0);

    // mid-count reset while out=6 with a carry in flight
    step(1'b1);
    for (int k = 0; k < 8; k++) step(1'b0);
    check("pre_mid", {4'b0, out4}, 8'd6);
    step(1'b1);
    check("mid_rst", {4'b0, out4}, 8'd0);
    step(1'b0);
    check("post_mid", {4'b0, out4}, 8'd1);

    // long random run with sporadic resets (8-bit runs >600 edges uninterrupted first)
    for (int k = 0; k < 620; k++) step(1'b0);
    for (int k = 0; k < 400; k++) step($urandom_range(0, 39) == 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
